ofmap_deskew_fifo: RTL

//  Sink for the skewed ofmap_out bus of the systolic array. Column x of a result vector exits the

---
 rtl/ofmap_deskew_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ofmap_deskew_fifo.sv
// ofmap_deskew_fifo: realigns the skewed systolic-array output columns
// and buffers aligned vectors in a show-ahead valid/ready FIFO.
module ofmap_deskew_fifo #(
   parameter int OFMAP_WIDTH = 32,
   parameter int ARRAY_WIDTH = 4,
   parameter int DEPTH       = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic signed [OFMAP_WIDTH-1:0] ofmap_in [ARRAY_WIDTH-1:0],
   output logic                          stall,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OFMAP_WIDTH-1:0] out_data [ARRAY_WIDTH-1:0],
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int VPW = (ARRAY_WIDTH > 1) ? ARRAY_WIDTH - 1 : 1;

   logic signed [OFMAP_WIDTH-1:0] col_w [ARRAY_WIDTH-1:0];
   logic signed [OFMAP_WIDTH-1:0] mem_q [DEPTH-1:0][ARRAY_WIDTH-1:0];

   logic [VPW-1:0] vp_q, vp_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           overflow_q, overflow_d;
   logic [CW:0]    occ;
   logic           wr_en, full, pop, push;

   // Column x gets ARRAY_WIDTH-1-x free-running delay stages so that all
   // columns of one vector line up in the same cycle.
   for (genvar x = 0; x < ARRAY_WIDTH; x++) begin : g_col
      localparam int D = ARRAY_WIDTH - 1 - x;
      if (D == 0) begin : g_pass
         assign col_w[x] = ofmap_in[x];
      end else begin : g_dly
         logic signed [OFMAP_WIDTH-1:0] dly_q [D-1:0];
         // shift the column through its delay chain every cycle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) dly_q[i] <= '0;
            end else begin
               dly_q[0] <= ofmap_in[x];
               for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
            end
         end
         assign col_w[x] = dly_q[D-1];
      end
   end

   // valid pipe tracks vectors travelling through the deskew stages
   always_comb begin
      vp_d = '0;
      if (ARRAY_WIDTH > 1) begin
         vp_d[0] = in_valid;
         for (int i = 1; i < VPW; i++) vp_d[i] = vp_q[i-1];
      end
   end

   assign wr_en = (ARRAY_WIDTH > 1) ? vp_q[VPW-1] : in_valid;

   // occupancy seen by upstream: buffered plus still in the deskew pipe
   always_comb begin
      occ = {1'b0, count_q};
      if (ARRAY_WIDTH > 1) begin
         for (int i = 0; i < VPW; i++) occ = occ + (CW+1)'(vp_q[i]);
      end
   end

   assign stall     = occ >= (CW+1)'(DEPTH);
   assign full      = count_q == CW'(DEPTH);
   assign out_valid = count_q != '0;
   assign pop       = out_valid & out_ready;
   assign push      = wr_en & (~full | pop);

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // next-state for pointers, occupancy and the sticky error flag
   always_comb begin
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d    = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      if (!push && pop) count_d = count_q - 1'b1;
      overflow_d = overflow_q | (in_valid & stall);
   end

   // control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vp_q       <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         vp_q       <= vp_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // storage array; contents are only visible through a valid read pointer
   always_ff @(posedge clk) begin
      if (push) begin
         for (int x = 0; x < ARRAY_WIDTH; x++) mem_q[wr_ptr_q][x] <= col_w[x];
      end
   end

   // show-ahead read port, forced to zero while empty
   always_comb begin
      for (int x = 0; x < ARRAY_WIDTH; x++) begin
         out_data[x] = out_valid ? mem_q[rd_ptr_q][x] : '0;
      end
   end

   assign count    = count_q;
   assign overflow = overflow_q;

endmodule
